// File: rtl/ram_refresh_if.sv
// Refresh request/acknowledge signals between ram_refresh_timer (master) and the RAM controller (slave).
interface ram_refresh_if;
  logic RefAck;
  logic RefReq;
  logic RefUrg;
  logic RefMiss;

  modport master (input RefAck, output RefReq, output RefUrg, output RefMiss);
  modport slave  (output RefAck, input RefReq, input RefUrg, input RefMiss);
endinterface

// File: rtl/ram_refresh_timer.sv
// DRAM refresh timer: period counter, owed-refresh backlog, ageing escalation and post-ack quiet window.
// Optional macro RAM_REFRESH_BURST_EN widens the backlog to 2 bits and lets a backlog of 2+ force RefUrg.
module ram_refresh_timer #(
  parameter int REF_PERIOD = 375,
  parameter int URG_DELAY  = 128,
  parameter int ACK_HOLD   = 4
) (
  input  logic          CLK,
  input  logic          RST,
  ram_refresh_if.master bus
);

  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int HW = $clog2(ACK_HOLD + 1);
`ifdef RAM_REFRESH_BURST_EN
  localparam int DW = 2;
`else
  localparam int DW = 1;
`endif

  localparam logic [TW-1:0] TCNT_LAST = TW'(REF_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(ACK_HOLD);
  localparam logic [DW-1:0] DEBT_MAX  = '1;

  logic [TW-1:0] tcnt, tcnt_next;
  logic          tick, tick_next;
  logic [DW-1:0] debt, debt_next;
  logic [7:0]    age, age_next;
  logic [HW-1:0] hold, hold_next;
  logic          req, req_next;
  logic          urg, urg_next;
  logic          miss, miss_next;
  logic          ack;

  assign ack = bus.RefAck;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    tcnt_next = (tcnt == TCNT_LAST) ? '0 : tcnt + 1'b1;
    tick_next = (tcnt == TCNT_LAST);
    debt_next = debt;
    miss_next = miss;
    age_next  = age;
    hold_next = hold;

    // The registered tick is consumed one edge after the wrap, which sets the tick-to-RefReq latency.
    if (tick && !ack) begin
      if (debt == DEBT_MAX) miss_next = 1'b1;
      else                  debt_next = debt + 1'b1;
    end else if (!tick && ack && (debt != '0)) begin
      debt_next = debt - 1'b1;
    end

    if (debt_next == '0)            age_next = '0;
    else if ((debt == '0) || ack)   age_next = '0;
    else if (age != 8'hFF)          age_next = age + 1'b1;

    if (ack)              hold_next = HOLD_LOAD;
    else if (hold != '0)  hold_next = hold - 1'b1;

    // Gating on the current hold as well keeps outputs low through edge E1+ACK_HOLD inclusive.
    req_next = (debt_next != '0) && (hold_next == '0) && (hold == '0);

    // Registered age gives the one-cycle lag between Age reaching URG_DELAY and RefUrg.
`ifdef RAM_REFRESH_BURST_EN
    urg_next = req_next && ((debt_next >= 2'd2) || (32'(age) >= URG_DELAY));
`else
    urg_next = req_next && (32'(age) >= URG_DELAY);
`endif
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments in sequential logic avoid evaluation-order races between registers.
    if (RST) begin
      tcnt <= '0;
      tick <= 1'b0;
      debt <= '0;
      age  <= '0;
      hold <= '0;
      req  <= 1'b0;
      urg  <= 1'b0;
      miss <= 1'b0;
    end else begin
      tcnt <= tcnt_next;
      tick <= tick_next;
      debt <= debt_next;
      age  <= age_next;
      hold <= hold_next;
      req  <= req_next;
      urg  <= urg_next;
      miss <= miss_next;
    end
  end

  assign bus.RefReq  = req;
  assign bus.RefUrg  = urg;
  assign bus.RefMiss = miss;

endmodule

// File: tb/tb_ram_refresh_timer.sv
// Table-driven bench for ram_refresh_timer; expected outputs are queued when a vector is driven and popped at sampling.
module tb_ram_refresh_timer;

`ifdef RAM_REFRESH_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    string name;
    int    at;    // edge index after the last reset edge; ack is sampled on this edge
    bit    rst;
    bit    ack;
    bit    req;
    bit    urg;
    bit    miss;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] val;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;

  vec_t vecs[$];
  exp_t sb[$];

  ram_refresh_if bus ();

  ram_refresh_timer #(
    .REF_PERIOD(375),
    .URG_DELAY (128),
    .ACK_HOLD  (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic add(input string name, input int at, input bit rst, input bit ack,
                     input bit req, input bit urg, input bit miss);
    vec_t v;
    v.name = name; v.at = at; v.rst = rst; v.ack = ack;
    v.req = req; v.urg = urg; v.miss = miss;
    vecs.push_back(v);
  endtask

  task automatic edge_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: req/urg/miss got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    int   fill;
    exp_t e;
    vec_t v;

    fill = BURST ? 1501 : 751;
    bus.RefAck = 1'b0;

    // Reset release, no ack
    add("a_reset_state",   0,    1, 0, 0, 0, 0);
    add("a_no_req_375",    375,  0, 0, 0, 0, 0);
    add("a_req_376",       376,  0, 0, 1, 0, 0);
    add("a_urg_not_504",   504,  0, 0, 1, 0, 0);
    add("a_urg_505",       505,  0, 0, 1, 1, 0);
    add("a_miss_750",      750,  0, 0, 1, 1, 0);
    add("a_tick2_751",     751,  0, 0, 1, 1, !BURST);
    add("a_miss_1500",     1500, 0, 0, 1, 1, !BURST);
    add("a_miss_1501",     1501, 0, 0, 1, 1, 1);
    // Ack 10 cycles after RefReq with one owed refresh
    add("b_reset",         0,    1, 0, 0, 0, 0);
    add("b_req",           376,  0, 0, 1, 0, 0);
    add("b_ack_e1",        387,  0, 1, 0, 0, 0);
    add("b_low_e2",        389,  0, 0, 0, 0, 0);
    add("b_low_e4",        391,  0, 0, 0, 0, 0);
    add("b_stay_low_e5",   392,  0, 0, 0, 0, 0);
    add("b_no_urg",        505,  0, 0, 0, 0, 0);
    add("b_req_tick2",     751,  0, 0, 1, 0, 0);
    add("b_age_879",       879,  0, 0, 1, 0, 0);
    add("b_urg_880",       880,  0, 0, 1, 1, 0);
    // Backlog of two, then one ack
    add("c_reset",         0,    1, 0, 0, 0, 0);
    add("c_backlog",       751,  0, 0, 1, 1, !BURST);
    add("c_ack_e1",        761,  0, 1, 0, 0, !BURST);
    add("c_low_e4",        765,  0, 0, 0, 0, !BURST);
    add("c_rereq_e5",      766,  0, 0, BURST, 0, !BURST);
    add("c_age_889",       889,  0, 0, BURST, 0, !BURST);
    add("c_urg_890",       890,  0, 0, BURST, BURST, !BURST);
    // Tick and ack on the same edge
    add("d_reset",         0,    1, 0, 0, 0, 0);
    add("d_pre_tick",      750,  0, 0, 1, 1, 0);
    add("d_tick_ack",      751,  0, 1, 0, 0, 0);
    add("d_low_e4",        755,  0, 0, 0, 0, 0);
    add("d_debt_kept",     756,  0, 0, 1, 0, 0);
    add("d_age_879",       879,  0, 0, 1, 0, 0);
    add("d_urg_880",       880,  0, 0, 1, 1, 0);
    add("d_pre_tick3",     1125, 0, 0, 1, 1, 0);
    add("d_tick3",         1126, 0, 0, 1, 1, !BURST);
    // Acks with nothing owed
    add("e_reset",         0,    1, 0, 0, 0, 0);
    add("e_ack_10",        10,   0, 1, 0, 0, 0);
    add("e_ack_20",        20,   0, 1, 0, 0, 0);
    add("e_no_underflow",  30,   0, 0, 0, 0, 0);
    add("e_no_req_375",    375,  0, 0, 0, 0, 0);
    add("e_req_376",       376,  0, 0, 1, 0, 0);
    add("e_urg_505",       505,  0, 0, 1, 1, 0);
    // Reset mid-hold with full backlog and miss set
    add("f_reset",         0,    1, 0, 0, 0, 0);
    add("f_full",          fill, 0, 0, 1, 1, 1);
    add("f_ack",           fill + 1, 0, 1, 0, 0, 1);
    add("f_rst_mid_hold",  0,    1, 0, 0, 0, 0);
    add("f_no_req_375",    375,  0, 0, 0, 0, 0);
    add("f_req_376",       376,  0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      e.name = v.name;
      e.val  = {v.req, v.urg, v.miss};
      sb.push_back(e);
      if (v.rst) begin
        RST = 1'b1;
        bus.RefAck = 1'b0;
        edge_step();
        RST = 1'b0;
        cur = 0;
      end else begin
        while (cur < v.at - 1) begin
          edge_step();
          cur++;
        end
        bus.RefAck = v.ack;
        edge_step();
        cur++;
        bus.RefAck = 1'b0;
      end
      e = sb.pop_front();
      check(e.name, {bus.RefReq, bus.RefUrg, bus.RefMiss}, e.val);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
